// File: rtl/ttt_pkg.sv
// Shared encodings for the tic-tac-toe move path: cell values, winner codes,
// keypad codes and the table of the eight winning lines.
package ttt_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_P1    = 2'd1;
    localparam logic [1:0] CELL_P2    = 2'd2;

    localparam logic [1:0] WIN_NONE   = 2'd0;
    localparam logic [1:0] WIN_DRAW   = 2'd3;

    // Keypad codes are row*3+col; 0..8 are board cells, 10 and 11 are ignored keys.
    localparam logic [3:0] KEY_LAST_CELL = 4'd8;
    localparam logic [3:0] KEY_NEW_GAME  = 4'd9;
    localparam logic [3:0] KEY_LAST_REAL = 4'd11;
    localparam logic [3:0] KEY_NONE      = 4'd14;
    localparam logic [3:0] KEY_MULTI     = 4'd15;

    typedef enum logic {
        DEB_ARMED,
        DEB_RELEASE
    } deb_state_t;

    localparam int WIN_LINES [8][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    // A completed line gives that player; a full board with no line is a draw.
    function automatic logic [1:0] calc_winner(input logic [17:0] b);
        logic [1:0] w;
        logic [1:0] a;
        logic       full;
        w    = WIN_NONE;
        full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (b[2*i +: 2] == CELL_EMPTY) full = 1'b0;
        end
        for (int l = 0; l < 8; l++) begin
            a = b[2*WIN_LINES[l][0] +: 2];
            if (a != CELL_EMPTY && a == b[2*WIN_LINES[l][1] +: 2] &&
                a == b[2*WIN_LINES[l][2] +: 2]) begin
                w = a;
            end
        end
        if (w == WIN_NONE && full) w = WIN_DRAW;
        return w;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: column synchroniser, row rotation, per-scan key code and
// press/release debounce producing a single key_valid pulse per press.
//
//  state       | meaning
//  DEB_ARMED   | waiting for DEB_SCANS identical scans of one valid key
//  DEB_RELEASE | key accepted; waiting for DEB_SCANS consecutive empty scans
module keypad_scanner
    import ttt_pkg::*;
#(
    parameter int SCAN_DIV  = 12500,
    parameter int DEB_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key_col,
    output logic [3:0] key_row,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEB_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_SCANS);

    logic [2:0]       col_meta;
    logic [2:0]       col_sync;
    logic [DIV_W-1:0] div_cnt;
    logic [8:0]       scan_bits;
    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       prev_code;
    logic [3:0]       scan_code;
    logic [3:0]       hit_cnt;
    logic [11:0]      scan_all;
    logic             div_tc;
    logic             scan_done;
    deb_state_t       state;

    assign div_tc    = (div_cnt == DIV_LAST);
    assign scan_done = div_tc && key_row[3];
    // Row 3 is never stored: its columns are used live at the end of the scan.
    assign scan_all  = {col_sync, scan_bits};

    // Two-flop synchroniser for the asynchronous column inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta <= '0;
            col_sync <= '0;
        end else begin
            col_meta <= key_col;
            col_sync <= col_meta;
        end
    end

    // Row slot timer, row rotation and capture of rows 0..2 at the end of each slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            key_row   <= 4'b0001;
            scan_bits <= '0;
        end else if (div_tc) begin
            div_cnt <= '0;
            key_row <= {key_row[2:0], key_row[3]};
            if (key_row[0]) scan_bits[2:0] <= col_sync;
            if (key_row[1]) scan_bits[5:3] <= col_sync;
            if (key_row[2]) scan_bits[8:6] <= col_sync;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Reduce the 12 sampled switches to one code, NONE or MULTI.
    always_comb begin
        scan_code = KEY_NONE;
        hit_cnt   = '0;
        for (int i = 0; i < 12; i++) begin
            if (scan_all[i]) begin
                hit_cnt   = hit_cnt + 4'd1;
                scan_code = 4'(i);
            end
        end
        if (hit_cnt > 4'd1) scan_code = KEY_MULTI;
    end

    // Saturating stability count for the armed state.
    always_comb begin
        cnt_inc = CNT_W'(1);
        if (scan_code == prev_code) begin
            cnt_inc = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + CNT_W'(1);
        end
    end

    // Debounce FSM; evaluated once per completed scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= DEB_ARMED;
            stable_cnt <= '0;
            prev_code  <= KEY_NONE;
            key_valid  <= 1'b0;
            key_code   <= KEY_NONE;
        end else begin
            key_valid <= 1'b0;
            if (scan_done) begin
                case (state)
                    DEB_ARMED: begin
                        prev_code <= scan_code;
                        if (scan_code <= KEY_LAST_REAL && cnt_inc == CNT_MAX) begin
                            key_valid  <= 1'b1;
                            key_code   <= scan_code;
                            stable_cnt <= '0;
                            state      <= DEB_RELEASE;
                        end else begin
                            stable_cnt <= cnt_inc;
                        end
                    end
                    DEB_RELEASE: begin
                        if (scan_code != KEY_NONE) begin
                            stable_cnt <= '0;
                        end else if (stable_cnt + CNT_W'(1) == CNT_MAX) begin
                            stable_cnt <= '0;
                            prev_code  <= KEY_NONE;
                            state      <= DEB_ARMED;
                        end else begin
                            stable_cnt <= stable_cnt + CNT_W'(1);
                        end
                    end
                    default: state <= DEB_ARMED;
                endcase
            end
        end
    end

endmodule

// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe move controller: applies debounced keypad presses to the board,
// tracks the turn and latches the winner until a new game.
module ttt_move_ctrl
    import ttt_pkg::*;
#(
    parameter int SCAN_DIV  = 12500,
    parameter int DEB_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  key_col,
    output logic [3:0]  key_row,
    output logic [17:0] board,
    output logic        turn,
    output logic [1:0]  winner,
    output logic        move_ok,
    output logic        move_err
);

    logic       key_valid;
    logic [3:0] key_code;
    logic       cell_key;
    logic       new_game;
    logic [1:0] cur_cell;

    keypad_scanner #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_SCANS (DEB_SCANS)
    ) u_scanner (
        .clk       (clk),
        .rst       (rst),
        .key_col   (key_col),
        .key_row   (key_row),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    assign cell_key = (key_code <= KEY_LAST_CELL);
    assign new_game = key_valid && (key_code == KEY_NEW_GAME);

    // Current contents of the cell addressed by the pressed key.
    always_comb begin
        cur_cell = CELL_EMPTY;
        for (int i = 0; i < 9; i++) begin
            if (key_code == 4'(i)) cur_cell = board[2*i +: 2];
        end
    end

    // Apply an accepted key: new game, legal move or rejected move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            board    <= '0;
            turn     <= 1'b0;
            move_ok  <= 1'b0;
            move_err <= 1'b0;
        end else begin
            move_ok  <= 1'b0;
            move_err <= 1'b0;
            if (new_game) begin
                board <= '0;
                turn  <= 1'b0;
            end else if (key_valid && cell_key) begin
                if (winner != WIN_NONE || cur_cell != CELL_EMPTY) begin
                    move_err <= 1'b1;
                end else begin
                    for (int i = 0; i < 9; i++) begin
                        if (key_code == 4'(i)) board[2*i +: 2] <= turn ? CELL_P2 : CELL_P1;
                    end
                    turn    <= ~turn;
                    move_ok <= 1'b1;
                end
            end
        end
    end

    // Winner follows the board by one clock and sticks until a new game.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner <= WIN_NONE;
        end else if (new_game) begin
            winner <= WIN_NONE;
        end else if (winner == WIN_NONE) begin
            winner <= calc_winner(board);
        end
    end

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Bench for ttt_move_ctrl with a fast scan (SCAN_DIV=4, DEB_SCANS=2): a keypad
// model drives key_col, expected move pulses are queued and checked by a monitor.
module tb_ttt_move_ctrl;

    localparam int SCAN_CLKS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  key_col;
    logic [3:0]  key_row;
    logic [17:0] board;
    logic        turn;
    logic [1:0]  winner;
    logic        move_ok;
    logic        move_err;
    logic [11:0] pressed;

    typedef struct {
        logic        ok;
        logic [17:0] board;
        logic        turn;
        logic [1:0]  win;
    } exp_t;

    exp_t        exp_q[$];
    logic [17:0] exp_board;
    logic        exp_turn;
    int          n_pass  = 0;
    int          n_total = 0;

    ttt_move_ctrl #(
        .SCAN_DIV  (4),
        .DEB_SCANS (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_col  (key_col),
        .key_row  (key_row),
        .board    (board),
        .turn     (turn),
        .winner   (winner),
        .move_ok  (move_ok),
        .move_err (move_err)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed switch connects its row drive to its column.
    always_comb begin
        key_col = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (key_row[r] && pressed[r*3+c]) key_col[c] = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    // Monitor: every move pulse must match the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (move_ok || move_err)) begin
                check("pulse_exclusive", {31'd0, move_ok & move_err}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_pulse: got move_ok=%0b move_err=%0b expected no pulse",
                             move_ok, move_err);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_ok", {31'd0, move_ok}, {31'd0, e.ok});
                    check("pulse_board", {14'd0, board}, {14'd0, e.board});
                    check("pulse_turn", {31'd0, turn}, {31'd0, e.turn});
                    @(negedge clk);
                    check("pulse_winner", {30'd0, winner}, {30'd0, e.win});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic hold_key(input int k, input int scans);
        @(negedge clk);
        pressed[k] = 1'b1;
        repeat (scans * SCAN_CLKS) @(negedge clk);
        pressed[k] = 1'b0;
        repeat (4 * SCAN_CLKS) @(negedge clk);
    endtask

    task automatic push_exp(input logic ok, input logic [1:0] win);
        exp_t e;
        e.ok    = ok;
        e.board = exp_board;
        e.turn  = exp_turn;
        e.win   = win;
        exp_q.push_back(e);
    endtask

    task automatic play(input int k, input logic [1:0] win_after);
        exp_board[2*k +: 2] = exp_turn ? 2'd2 : 2'd1;
        exp_turn = ~exp_turn;
        push_exp(1'b1, win_after);
        hold_key(k, 4);
    endtask

    task automatic new_game(input string tag);
        hold_key(9, 4);
        exp_board = '0;
        exp_turn  = 1'b0;
        check({tag, "_board"}, {14'd0, board}, 32'd0);
        check({tag, "_turn"}, {31'd0, turn}, 32'd0);
        check({tag, "_winner"}, {30'd0, winner}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        pressed   = '0;
        exp_board = '0;
        exp_turn  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_key_row", {28'd0, key_row}, 32'h1);
        check("rst_board", {14'd0, board}, 32'd0);
        check("rst_turn", {31'd0, turn}, 32'd0);
        check("rst_winner", {30'd0, winner}, 32'd0);
        check("rst_move_ok", {31'd0, move_ok}, 32'd0);
        check("rst_move_err", {31'd0, move_err}, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("row_adv1", {28'd0, key_row}, 32'h2);
        repeat (4) @(posedge clk);
        #1 check("row_adv2", {28'd0, key_row}, 32'h4);

        // Long hold of cell 4: exactly one accepted move.
        exp_board = 18'h00100;
        exp_turn  = 1'b1;
        push_exp(1'b1, 2'd0);
        hold_key(4, 13);
        check("first_board", {14'd0, board}, 32'h00100);
        check("first_turn", {31'd0, turn}, 32'd1);

        // Occupied cell.
        push_exp(1'b0, 2'd0);
        hold_key(4, 4);

        // Bouncing key: state changes every scan.
        for (int i = 0; i < 6; i++) begin
            pressed[4] = (i % 2 == 0);
            repeat (SCAN_CLKS) @(negedge clk);
        end
        pressed = '0;
        repeat (4 * SCAN_CLKS) @(negedge clk);

        // Two keys at once.
        pressed[0] = 1'b1;
        pressed[8] = 1'b1;
        repeat (6 * SCAN_CLKS) @(negedge clk);
        pressed = '0;
        repeat (4 * SCAN_CLKS) @(negedge clk);
        check("noise_board", {14'd0, board}, 32'h00100);

        new_game("ng1");

        // P1 wins on the top row.
        play(0, 2'd0);
        play(3, 2'd0);
        play(1, 2'd0);
        play(4, 2'd0);
        play(2, 2'd1);
        check("win_board", {14'd0, board}, 32'h00295);
        check("win_winner", {30'd0, winner}, 32'd1);

        // Move after game over.
        push_exp(1'b0, 2'd1);
        hold_key(5, 4);

        new_game("ng2");

        // Full board without a line.
        play(0, 2'd0);
        play(1, 2'd0);
        play(2, 2'd0);
        play(4, 2'd0);
        play(3, 2'd0);
        play(5, 2'd0);
        play(7, 2'd0);
        play(6, 2'd0);
        play(8, 2'd3);
        check("draw_board", {14'd0, board}, 32'h16A59);
        check("draw_winner", {30'd0, winner}, 32'd3);

        // Reset while a press is part-way through debounce.
        @(negedge clk);
        pressed[7] = 1'b1;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_key_row", {28'd0, key_row}, 32'h1);
        check("mid_rst_board", {14'd0, board}, 32'd0);
        check("mid_rst_turn", {31'd0, turn}, 32'd0);
        check("mid_rst_winner", {30'd0, winner}, 32'd0);
        check("mid_rst_move_ok", {31'd0, move_ok}, 32'd0);
        check("mid_rst_move_err", {31'd0, move_err}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        exp_board = '0;
        exp_turn  = 1'b0;
        exp_board[15:14] = 2'd1;
        exp_turn  = 1'b1;
        push_exp(1'b1, 2'd0);
        repeat (5 * SCAN_CLKS) @(negedge clk);
        pressed = '0;
        repeat (4 * SCAN_CLKS) @(negedge clk);
        check("post_rst_board", {14'd0, board}, 32'h04000);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
